// File: rtl/activation_lut_pkg.sv
// Shared types and defaults for the activation lookup blocks: loader FSM states,
// table-depth helper and the precision defaults used by the fixed-table variants.
package activation_lut_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    DRAIN   = 2'd2,
    READY   = 2'd3
  } lut_state_e;

  localparam int DEFAULT_IN_PRECISION  = 4;
  localparam int DEFAULT_OUT_PRECISION = 4;
  localparam int DEFAULT_PARALLELISM   = 2;

  function automatic int LUT_DEPTH(input int width);
    return 2 ** width;
  endfunction

endpackage

// File: rtl/lut_regfile.sv
// Activation table storage: one write port from the loader and RD_PORTS
// combinational read ports, one per lane, all sharing the same entries.
module lut_regfile
  import activation_lut_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_IN_PRECISION,
  parameter int DATA_W   = DEFAULT_OUT_PRECISION,
  parameter int RD_PORTS = DEFAULT_PARALLELISM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
  output logic [RD_PORTS*DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = LUT_DEPTH(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Address width equals log2(DEPTH), so every raw lane pattern is a valid entry.
  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    assign rdata_o[gi*DATA_W +: DATA_W] = mem_q[raddr_i[gi*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/programmable_activation_lut.sv
// Run-time loadable activation LUT: a loader FSM streams the table in, then
// lanes are looked up with a single registered, back-pressurable output stage.
module programmable_activation_lut
  import activation_lut_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = DEFAULT_IN_PRECISION,
  parameter int DATA_OUT_0_PRECISION_0 = DEFAULT_OUT_PRECISION,
  parameter int DATA_IN_0_PARALLELISM  = DEFAULT_PARALLELISM
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                cfg_start,
  input  logic [DATA_OUT_0_PRECISION_0-1:0]                   cfg_data,
  input  logic                                                cfg_valid,
  output logic                                                cfg_ready,
  output logic                                                table_loaded,
  output logic                                                load_done,
  input  logic [DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                                data_in_0_valid,
  output logic                                                data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                                data_out_0_valid,
  input  logic                                                data_out_0_ready
);

  localparam int AW    = DATA_IN_0_PRECISION_0;
  localparam int DEPTH = LUT_DEPTH(AW);
  localparam int OUT_W = DATA_IN_0_PARALLELISM * DATA_OUT_0_PRECISION_0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  lut_state_e        state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              load_done_q, load_done_d;
  logic [OUT_W-1:0]  rd_data;
  logic [AW-1:0]     wr_addr;
  logic              cfg_wr, wr_last, accept;

  assign cfg_wr  = cfg_valid && cfg_ready;
  // A restart pulse redirects a same-cycle beat to entry 0.
  assign wr_addr = cfg_start ? '0 : ptr_q;
  assign wr_last = cfg_wr && !cfg_start && (ptr_q == LAST_IDX);
  assign accept  = data_in_0_valid && data_in_0_ready;

  lut_regfile #(
    .ADDR_W   (AW),
    .DATA_W   (DATA_OUT_0_PRECISION_0),
    .RD_PORTS (DATA_IN_0_PARALLELISM)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_wr),
    .waddr_i (wr_addr),
    .wdata_i (cfg_data),
    .raddr_i (data_in_0),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: begin
        if (cfg_start) begin
          state_d = LOADING;
          ptr_d   = '0;
        end
      end
      LOADING: begin
        if (cfg_start) begin
          ptr_d = cfg_wr ? AW'(1) : '0;
        end else if (cfg_wr) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_IDX) state_d = READY;
        end
      end
      READY: begin
        if (cfg_start) begin
          ptr_d   = '0;
          state_d = (out_valid_q && !data_out_0_ready) ? DRAIN : LOADING;
        end
      end
      DRAIN: begin
        if (!out_valid_q || data_out_0_ready) state_d = LOADING;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    cfg_ready       = 1'b0;
    table_loaded    = 1'b0;
    data_in_0_ready = 1'b0;
    unique case (state_q)
      LOADING: cfg_ready = 1'b1;
      READY: begin
        table_loaded    = 1'b1;
        data_in_0_ready = !out_valid_q || data_out_0_ready;
      end
      default: ;
    endcase
  end

  // Output stage drains independently of state so a held beat survives a reload.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    load_done_d = wr_last;
    if (accept) begin
      out_d       = rd_data;
      out_valid_d = 1'b1;
    end else if (data_out_0_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign data_out_0       = out_q;
  assign data_out_0_valid = out_valid_q;
  assign load_done        = load_done_q;

endmodule

// File: tb/tb_programmable_activation_lut.sv
// Directed bench for programmable_activation_lut: table loads, streaming lookups,
// backpressure, reload-while-stalled, restarted load and reset during load.
module tb_programmable_activation_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [3:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       table_loaded;
  logic       load_done;
  logic [7:0] data_in_0;
  logic       data_in_0_valid;
  logic       data_in_0_ready;
  logic [7:0] data_out_0;
  logic       data_out_0_valid;
  logic       data_out_0_ready;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct packed {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [21];
  logic [3:0] silu [16] = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                            4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
  logic [3:0] ld_tbl [16];

  programmable_activation_lut dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_data         (cfg_data),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .table_loaded     (table_loaded),
    .load_done        (load_done),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Streams ld_tbl into the loader, optionally preceded by a cfg_start pulse.
  task automatic load_table(input bit do_start, input string tag);
    int rdy_cnt  = 0;
    int done_cnt = 0;
    if (do_start) begin
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      cfg_data  = ld_tbl[i];
      cfg_valid = 1'b1;
      #1;
      if (cfg_ready) rdy_cnt++;
      tick();
      if (load_done) done_cnt++;
    end
    cfg_valid = 1'b0;
    chk({tag, "_ready_beats"}, rdy_cnt, 16);
    chk({tag, "_load_done_hi"}, load_done, 1'b1);
    chk({tag, "_table_loaded"}, table_loaded, 1'b1);
    chk({tag, "_cfg_ready_off"}, cfg_ready, 1'b0);
    tick();
    chk({tag, "_load_done_pulse"}, load_done, 1'b0);
    chk({tag, "_load_done_count"}, done_cnt, 1);
    $display("load %s: %0d ready beats, %0d done pulses", tag, rdy_cnt, done_cnt);
  endtask

  // Single beat with downstream ready; checks the 1-cycle latency result.
  task automatic lookup(input logic [7:0] din, input logic [7:0] exp, input string tag);
    data_in_0       = din;
    data_in_0_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, data_in_0_ready, 1'b1);
    tick();
    data_in_0_valid = 1'b0;
    chk({tag, "_data"}, data_out_0, exp);
    chk({tag, "_valid"}, data_out_0_valid, 1'b1);
    $display("lookup %s: in=0x%02h out=0x%02h", tag, din, data_out_0);
    tick();
    chk({tag, "_valid_clear"}, data_out_0_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    data_in_0 = '0; data_in_0_valid = 1'b0; data_out_0_ready = 1'b1;

    // Hand-computed lookups against the SiLU table, then a generated sweep.
    vecs[0] = '{din: 8'h83, exp: 8'hF2};
    vecs[1] = '{din: 8'h47, exp: 8'h36};
    vecs[2] = '{din: 8'hE1, exp: 8'hF1};
    vecs[3] = '{din: 8'h5F, exp: 8'h40};
    vecs[4] = '{din: 8'h92, exp: 8'hF1};
    for (int i = 0; i < 16; i++) begin
      vecs[5+i].din = {4'(15 - i), 4'(i)};
      vecs[5+i].exp = {silu[15-i], silu[i]};
    end

    tick(); tick();
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_table_loaded", table_loaded, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_data_out", data_out_0, 8'h00);
    chk("rst_out_valid", data_out_0_valid, 1'b0);
    chk("rst_in_ready", data_in_0_ready, 1'b0);
    rst = 1'b0;

    data_in_0 = 8'h83; data_in_0_valid = 1'b1;
    tick();
    chk("empty_in_ready", data_in_0_ready, 1'b0);
    chk("empty_no_output", data_out_0_valid, 1'b0);
    data_in_0_valid = 1'b0;

    for (int i = 0; i < 16; i++) ld_tbl[i] = silu[i];
    load_table(1'b1, "silu");
    lookup(8'h83, 8'hF2, "lanes_3_8");

    // Back-to-back stream with downstream always ready: no bubbles.
    for (int i = 0; i < 21; i++) begin
      data_in_0       = vecs[i].din;
      data_in_0_valid = 1'b1;
      tick();
      chk($sformatf("stream%0d_data", i), data_out_0, vecs[i].exp);
      chk($sformatf("stream%0d_valid", i), data_out_0_valid, 1'b1);
      $display("stream %0d: in=0x%02h out=0x%02h", i, vecs[i].din, data_out_0);
    end
    data_in_0_valid = 1'b0;
    tick();
    chk("stream_drained", data_out_0_valid, 1'b0);

    // Backpressure: index 7 held for 3 stalled cycles, next beat waits.
    data_out_0_ready = 1'b0;
    data_in_0 = 8'h07; data_in_0_valid = 1'b1;
    tick();
    data_in_0 = 8'h21;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", i), data_in_0_ready, 1'b0);
      chk($sformatf("stall%0d_data", i), data_out_0, 8'h06);
      chk($sformatf("stall%0d_valid", i), data_out_0_valid, 1'b1);
      tick();
    end
    data_out_0_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", data_in_0_ready, 1'b1);
    tick();
    data_in_0_valid = 1'b0;
    chk("stall_next_beat", data_out_0, 8'h11);
    chk("stall_next_valid", data_out_0_valid, 1'b1);
    $display("backpressure: released beat out=0x%02h", data_out_0);
    tick();

    // Reload while an output beat is stalled: DRAIN, deliver, then LOADING.
    data_out_0_ready = 1'b0;
    data_in_0 = 8'h09; data_in_0_valid = 1'b1;
    tick();
    data_in_0_valid = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("drain_cfg_ready", cfg_ready, 1'b0);
    chk("drain_in_ready", data_in_0_ready, 1'b0);
    chk("drain_held_data", data_out_0, 8'h0F);
    chk("drain_held_valid", data_out_0_valid, 1'b1);
    tick();
    chk("drain_still_waiting", cfg_ready, 1'b0);
    data_out_0_ready = 1'b1;
    tick();
    chk("drain_delivered", data_out_0_valid, 1'b0);
    chk("drain_to_loading", cfg_ready, 1'b1);
    for (int i = 0; i < 16; i++) ld_tbl[i] = 4'(i);
    load_table(1'b0, "identity");
    lookup(8'h29, 8'h29, "identity_9");

    // Restart at entry 5: the second pass defines the whole table.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_data = 4'hA; cfg_valid = 1'b1;
      tick();
    end
    cfg_start = 1'b1; cfg_data = 4'hF;
    tick();
    cfg_start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cfg_data = 4'(15 - i);
      tick();
      if (i == 14) chk("restart_no_early_done", load_done, 1'b0);
    end
    cfg_valid = 1'b0;
    chk("restart_load_done", load_done, 1'b1);
    chk("restart_table_loaded", table_loaded, 1'b1);
    tick();
    lookup(8'h04, 8'hFB, "restart_idx4");

    // Reset after 10 entries of a load discards everything.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_data = silu[i]; cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_data_out", data_out_0, 8'h00);
    chk("midrst_out_valid", data_out_0_valid, 1'b0);
    chk("midrst_table_loaded", table_loaded, 1'b0);
    chk("midrst_in_ready", data_in_0_ready, 1'b0);
    chk("midrst_cfg_ready", cfg_ready, 1'b0);
    data_in_0 = 8'h83; data_in_0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_reject%0d_ready", i), data_in_0_ready, 1'b0);
      chk($sformatf("midrst_reject%0d_valid", i), data_out_0_valid, 1'b0);
    end
    data_in_0_valid = 1'b0;
    for (int i = 0; i < 16; i++) ld_tbl[i] = silu[i];
    load_table(1'b1, "reload_silu");
    lookup(8'h83, 8'hF2, "reload_lanes_3_8");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/programmable_activation_lut.md
Name: programmable_activation_lut

Overview:
Run-time loadable activation lookup table for the fixed-point activation path. Instead of a hard-coded case table, a config-side writer streams table entries into an internal register file. The datapath then serves streaming lookups with valid/ready handshakes and one registered stage. One instance can hold SiLU, GELU, ReLU or any other 2^DATA_IN_0_PRECISION_0-entry mapping, and can be re-programmed between layers.

Parameters:
DATA_IN_0_PRECISION_0, 4, input bit width; table depth = 2**DATA_IN_0_PRECISION_0
DATA_OUT_0_PRECISION_0, 4, table entry / output bit width
DATA_IN_0_PARALLELISM, 2, lanes looked up per beat (independent read ports, shared table)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_start  input  1  pulse; begin (re)loading the table from entry 0
cfg_data  input  DATA_OUT_0_PRECISION_0  table entry for current write pointer
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts cfg_data
table_loaded  output  1  high while a complete table is resident
load_done  output  1  one-cycle pulse when the last entry is written
data_in_0  input  DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0  packed lane indices, lane 0 in LSBs
data_in_0_valid  input  1  input beat valid
data_in_0_ready  output  1  input beat accepted
data_out_0  output  DATA_IN_0_PARALLELISM*DATA_OUT_0_PRECISION_0  packed lane results
data_out_0_valid  output  1  output beat valid
data_out_0_ready  input  1  downstream accepts

Behaviour:
- Reset (sync, active-high, on clk edge):
  - state=EMPTY; write pointer=0; all table entries=0.
  - cfg_ready=0, table_loaded=0, load_done=0.
  - data_out_0=0, data_out_0_valid=0, data_in_0_ready=0.
  - Reset mid-load or mid-stream discards everything.
- Lane indexing: each lane's input is an unsigned address of its raw bit pattern. Two's-complement negatives land in the upper half, so 4'b1000 is address 8.
- States:
  - EMPTY: cfg_ready=0, data_in_0_ready=0.
    - cfg_start → LOADING, pointer=0.
  - LOADING: cfg_ready=1, data_in_0_ready=0, table_loaded=0.
    - On cfg_valid&&cfg_ready: entry[ptr]<=cfg_data, ptr++.
    - On the write with ptr==DEPTH-1: → READY, load_done pulses the following cycle, ptr wraps to 0.
    - cfg_start in LOADING restarts at ptr=0, and a same-cycle cfg beat is written to entry 0.
    - cfg_valid and cfg_data are ignored outside LOADING.
  - READY: table_loaded=1, cfg_ready=0.
    - cfg_start → DRAIN if data_out_0_valid && !data_out_0_ready; otherwise → LOADING directly.
  - DRAIN: data_in_0_ready=0; → LOADING once the output register empties.
- Datapath in READY:
  - data_in_0_ready = (state==READY) && (!data_out_0_valid || data_out_0_ready), with no combinational dependence on data_in_0_valid.
  - On accept, data_out_0 <= per-lane entry[idx] and data_out_0_valid<=1 next cycle. Latency is exactly 1 cycle.
  - Output register holds data and valid stable while stalled.
  - Valid clears on handshake with no new accept.
  - Full throughput: 1 beat/cycle when downstream is always ready.
- Simultaneous events:
  - cfg_start and an input accept in the same READY cycle: the accept completes using the old table, then the state leaves READY.
  - A beat already in the output register is preserved through reload and must be consumed before LOADING (DRAIN).
- The table is never read while LOADING, so there are no read-during-write hazards.
- Width rule: outputs are raw entries; the block performs no arithmetic, rounding or saturation.

Decomposition:
- Shared package activation_lut_pkg:
  - state enum {EMPTY, LOADING, DRAIN, READY}
  - LUT_DEPTH function (2**width)
  - Default precision constants shared with the fixed-table activation modules.
- One natural sub-module: lut_regfile, holding DEPTH×DATA_OUT_0_PRECISION_0 registers with one write port and DATA_IN_0_PARALLELISM combinational read ports.
- Control FSM and output register stay in the top module.

Test Plan:
- Load SiLU table {0,1,1,2,3,4,5,6,F,F,F,F,F,F,F,0}:
  - cfg_ready high for exactly 16 accepted beats.
  - load_done pulses once.
  - table_loaded=1.
  - Input lanes {3,8} → output lanes {2,F} one cycle later.
- Back-to-back stream with data_out_0_ready=1: indices 0..15 on lane 0 → 16 consecutive valid outputs matching the table, no bubbles.
- Backpressure: hold data_out_0_ready=0 for 3 cycles with input index 7 (expect 6):
  - data_in_0_ready=0 throughout the stall.
  - data_out_0 stays 6 and valid stays 1.
  - The next beat is accepted only after the handshake.
- Reload during a stalled output:
  - cfg_start while output holds a value → DRAIN.
  - The held value is delivered, then LOADING.
  - Load an identity table; index 9 → 9.
- cfg_start at entry 5 of a load: pointer restarts; the new 16 entries fully define the table, and index 4 returns the new entry.
- Reset asserted mid-load (after 10 entries): all outputs 0, table_loaded=0, data_in_0_ready=0, and input is not accepted until a fresh full load.
